// File: rtl/bitblade_mac_acc.sv
// Pipelined bit-fusion inner-product accumulator: S1 registers 4x4 nibble partial
// products per lane, S2 shifts/sums them and accumulates; READ returns acc via a handshake.
module bitblade_mac_acc #(
    parameter int LANES = 4,
    parameter int ACC_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic               in_mode,
    input  logic               in_sign,
    input  logic [8*LANES-1:0] in_a,
    input  logic [8*LANES-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_c,
    output logic               out_ovf
);
    localparam int SUM_W = 18 + $clog2(LANES);

    localparam logic [1:0] OP_MAC  = 2'd0;
    localparam logic [1:0] OP_CLR  = 2'd1;
    localparam logic [1:0] OP_READ = 2'd2;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic accept;
    assign accept = in_valid && in_ready;

    logic s1_valid_q, s1_clr_q, s1_mode_q, s1_sign_q;
    logic signed [SUM_W-1:0] lane_sum [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [3:0] a_lo, a_hi, b_lo, b_hi;
            logic signed [9:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;
            logic signed [9:0] hh_d, hl_d, lh_d, ll_d;
            logic signed [9:0] hh_q, hl_q, lh_q, ll_q;
            logic signed [SUM_W-1:0] hh_e, hl_e, lh_e, ll_e;

            assign a_lo = in_a[8*gi +: 4];
            assign a_hi = in_a[8*gi+4 +: 4];
            assign b_lo = in_b[8*gi +: 4];
            assign b_hi = in_b[8*gi+4 +: 4];

            // A low nibble carries a sign only when it is a stand-alone 4-bit operand.
            assign a_lo_x = {{6{in_sign & in_mode & a_lo[3]}}, a_lo};
            assign b_lo_x = {{6{in_sign & in_mode & b_lo[3]}}, b_lo};
            assign a_hi_x = {{6{in_sign & a_hi[3]}}, a_hi};
            assign b_hi_x = {{6{in_sign & b_hi[3]}}, b_hi};

            assign hh_d = a_hi_x * b_hi_x;
            assign ll_d = a_lo_x * b_lo_x;
            assign hl_d = in_mode ? 10'sd0 : a_hi_x * b_lo_x;
            assign lh_d = in_mode ? 10'sd0 : a_lo_x * b_hi_x;

            always_ff @(posedge clk) begin
                if (reset) begin
                    hh_q <= '0;
                    hl_q <= '0;
                    lh_q <= '0;
                    ll_q <= '0;
                end else if (accept) begin
                    hh_q <= hh_d;
                    hl_q <= hl_d;
                    lh_q <= lh_d;
                    ll_q <= ll_d;
                end
            end

            assign hh_e = SUM_W'(hh_q);
            assign hl_e = SUM_W'(hl_q);
            assign lh_e = SUM_W'(lh_q);
            assign ll_e = SUM_W'(ll_q);

            assign lane_sum[gi] = s1_mode_q ? (hh_e + ll_e)
                                            : ((hh_e <<< 8) + ((hl_e + lh_e) <<< 4) + ll_e);
        end
    endgenerate

    logic signed [SUM_W-1:0] beat_sum;
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + lane_sum[i];
        end
    end

    logic [ACC_W-1:0] beat_x, add_res, acc_q, acc_d;
    logic [ACC_W:0]   add_u;
    logic             sgn_ovf, ovf_add, ovf_q, ovf_d;

    assign beat_x  = ACC_W'(beat_sum);
    assign add_u   = {1'b0, acc_q} + {1'b0, beat_x};
    assign add_res = add_u[ACC_W-1:0];
    assign sgn_ovf = (acc_q[ACC_W-1] == beat_x[ACC_W-1]) && (add_res[ACC_W-1] != acc_q[ACC_W-1]);
    assign ovf_add = s1_sign_q ? sgn_ovf : add_u[ACC_W];

    logic [1:0]       state_q, state_d;
    logic             drain_q, drain_d;
    logic             out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic [ACC_W-1:0] out_c_q, out_c_d;
    logic             in_ready_q, rd_clear;

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        out_ovf_d   = out_ovf_q;
        rd_clear    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept && in_op == OP_READ) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Second drain cycle: every MAC accepted before the READ has retired.
                if (drain_q) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    out_c_d     = acc_q;
                    out_ovf_d   = ovf_q;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_RUN;
                    out_valid_d = 1'b0;
                    rd_clear    = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (rd_clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (s1_valid_q) begin
            if (s1_clr_q) begin
                acc_d = beat_x;
                ovf_d = 1'b0;
            end else begin
                acc_d = add_res;
                ovf_d = ovf_q | ovf_add;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_clr_q    <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_sign_q   <= 1'b0;
            state_q     <= ST_RUN;
            drain_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            s1_valid_q <= accept && (in_op == OP_MAC || in_op == OP_CLR);
            if (accept) begin
                s1_clr_q  <= (in_op == OP_CLR);
                s1_mode_q <= in_mode;
                s1_sign_q <= in_sign;
            end
            state_q     <= state_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_ovf_q   <= out_ovf_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d == ST_RUN);
        end
    end

    // Ready is forced low while reset is held so no beat is offered into a clearing pipe.
    assign in_ready  = in_ready_q && !reset;
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bitblade_mac_acc.sv
// Bench for bitblade_mac_acc (ACC_W=20): directed cases with literal results, then
// randomized traffic checked every cycle against a timestamp-based arithmetic model.
module tb_bitblade_mac_acc;
    localparam int LANES = 4;
    localparam int ACC_W = 20;
    localparam longint MOD  = longint'(1) << ACC_W;
    localparam longint HALF = MOD / 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic               in_mode;
    logic               in_sign;
    logic [8*LANES-1:0] in_a;
    logic [8*LANES-1:0] in_b;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_c;
    logic               out_ovf;

    bitblade_mac_acc #(.LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_mode(in_mode),
        .in_sign(in_sign), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d time=%0t", name, got, want, $time);
        end
    endtask

    function automatic longint beat_value(input bit mode, input bit sign,
                                          input logic [31:0] a, input logic [31:0] b);
        longint s, x, y;
        s = 0;
        if (!mode) begin
            for (int i = 0; i < LANES; i++) begin
                x = longint'(a[8*i +: 8]);
                y = longint'(b[8*i +: 8]);
                if (sign && x >= 128) x -= 256;
                if (sign && y >= 128) y -= 256;
                s += x * y;
            end
        end else begin
            for (int j = 0; j < 2*LANES; j++) begin
                x = longint'(a[4*j +: 4]);
                y = longint'(b[4*j +: 4]);
                if (sign && x >= 8) x -= 16;
                if (sign && y >= 8) y -= 16;
                s += x * y;
            end
        end
        return s;
    endfunction

    // Model: a beat accepted at edge n lands in acc at edge n+2; READ result appears
    // two edges after acceptance and is held until the handshake.
    typedef struct { int due; bit clr; bit sign; longint sum; } pend_t;
    pend_t  pq[$];
    pend_t  p;
    int     cyc = 0;
    bit     live = 0;
    longint m_acc = 0, u, raw, sa, sx;
    bit     m_ovf = 0;
    bit     m_ready = 0, m_valid = 0, m_out_ovf = 0;
    longint m_c = 0;
    int     drain = 0;

    always @(posedge clk) begin
        cyc++;
        live = 1;
        if (reset) begin
            pq.delete();
            m_acc = 0; m_ovf = 0; m_ready = 1; m_valid = 0;
            m_c = 0; m_out_ovf = 0; drain = 0;
        end else begin
            while (pq.size() > 0 && pq[0].due == cyc) begin
                p = pq.pop_front();
                u = ((p.sum % MOD) + MOD) % MOD;
                if (p.clr) begin
                    m_acc = u;
                    m_ovf = 0;
                end else begin
                    raw = m_acc + u;
                    if (p.sign) begin
                        sa = (m_acc >= HALF) ? m_acc - MOD : m_acc;
                        sx = sa + p.sum;
                        if (sx >= HALF || sx < -HALF) m_ovf = 1;
                    end else if (raw >= MOD) begin
                        m_ovf = 1;
                    end
                    m_acc = raw % MOD;
                end
            end
            if (m_valid && out_ready) begin
                $display("READ c=%0d ovf=%0d cycle=%0d", m_c, m_out_ovf, cyc);
                m_valid = 0; m_acc = 0; m_ovf = 0; m_ready = 1;
            end else if (drain > 0) begin
                drain--;
                if (drain == 0) begin
                    m_valid = 1; m_c = m_acc; m_out_ovf = m_ovf;
                end
            end else if (m_ready && in_valid) begin
                if (in_op == 2'd0 || in_op == 2'd1)
                    pq.push_back('{cyc + 2, in_op == 2'd1, in_sign,
                                   beat_value(in_mode, in_sign, in_a, in_b)});
                else if (in_op == 2'd2) begin
                    m_ready = 0;
                    drain = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("in_ready", longint'(in_ready), longint'(m_ready && !reset));
            check("out_valid", longint'(out_valid), longint'(m_valid));
            if (m_valid) begin
                check("out_c", longint'(out_c), m_c);
                check("out_ovf", longint'(out_ovf), longint'(m_out_ovf));
            end
        end
    end

    // All driving happens 1ns after a rising edge; tasks are entered at that point.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!m_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_ready) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic send(input logic [1:0] op, input bit mode, input bit sign,
                        input logic [31:0] a, input logic [31:0] b);
        wait_ready("send");
        in_valid = 1; in_op = op; in_mode = mode; in_sign = sign; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic reset_checks(input string tag);
        reset = 1;
        @(posedge clk); #1;
        check({tag, "_rst_ready"}, longint'(in_ready), 0);
        check({tag, "_rst_valid"}, longint'(out_valid), 0);
        check({tag, "_rst_c"}, longint'(out_c), 0);
        check({tag, "_rst_ovf"}, longint'(out_ovf), 0);
        reset = 0;
        @(posedge clk); #1;
        check({tag, "_ready_after"}, longint'(in_ready), 1);
    endtask

    task automatic do_read(input string tag, input longint want_c, input bit want_ovf,
                           input int hold, input bit rst_in_hold);
        int k;
        logic [ACC_W-1:0] c0;
        wait_ready(tag);
        in_valid = 1; in_op = 2'd2;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 0;
        k = 1;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, k, 3);
        check({tag, "_c"}, longint'(out_c), want_c);
        check({tag, "_ovf"}, longint'(out_ovf), longint'(want_ovf));
        check({tag, "_model_c"}, m_c, want_c);
        c0 = out_c;
        if (hold > 0) begin
            in_valid = 1; in_op = 2'd0; in_mode = 0; in_sign = 0;
            in_a = 32'h01010101; in_b = 32'h01010101;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, longint'(out_valid), 1);
                check({tag, "_hold_ready"}, longint'(in_ready), 0);
                check({tag, "_hold_c"}, longint'(out_c), longint'(c0));
            end
            if (rst_in_hold) begin
                in_valid = 0;
                out_ready = 1;
                reset_checks(tag);
                return;
            end
            out_ready = 1;
            @(posedge clk); #1;
            check({tag, "_hs_valid"}, longint'(out_valid), 0);
            check({tag, "_hs_ready"}, longint'(in_ready), 1);
            @(posedge clk); #1;
            in_valid = 0;
        end
        out_ready = 1;
    endtask

    initial begin
        reset = 1; in_valid = 0; in_op = 2'd3; in_mode = 0; in_sign = 0;
        in_a = '0; in_b = '0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", longint'(out_valid), 0);
        check("reset_c", longint'(out_c), 0);
        reset = 0;
        @(posedge clk); #1;

        send(2'd0, 0, 0, 32'h01020304, 32'h05060708);
        do_read("u8", 70, 0, 0, 0);
        send(2'd1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_read("u4", 1800, 0, 0, 0);
        send(2'd1, 1, 1, 32'h88888888, 32'h88888888);
        do_read("s4", 512, 0, 0, 0);
        send(2'd0, 0, 1, 32'h000000FF, 32'h00000002);
        do_read("s8", MOD - 2, 0, 0, 0);
        send(2'd0, 0, 1, 32'h00000003, 32'h00000004);
        do_read("s8_clr", 12, 0, 0, 0);
        repeat (5) send(2'd0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_read("ovf", 251924, 1, 0, 0);
        do_read("ovf_clr", 0, 0, 0, 0);
        do_read("empty", 0, 0, 0, 0);
        send(2'd3, 0, 0, 32'h12345678, 32'h12345678);
        send(2'd0, 0, 0, 32'h00000010, 32'h00000003);
        do_read("bp", 48, 0, 3, 0);
        do_read("bp_held", 4, 0, 0, 0);
        send(2'd0, 0, 0, 32'h01020304, 32'h05060708);
        reset_checks("mid_pipe");
        do_read("after_rst", 0, 0, 0, 0);
        send(2'd0, 0, 0, 32'h00000009, 32'h00000009);
        do_read("hold_rst", 81, 0, 2, 1);
        do_read("after_hold_rst", 0, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 15);
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_op     = (r < 9) ? 2'd0 : (r < 11) ? 2'd1 : (r == 11) ? 2'd2 : 2'd3;
            in_mode   = $urandom_range(0, 1) == 1;
            in_sign   = $urandom_range(0, 1) == 1;
            in_a      = $urandom;
            in_b      = $urandom;
            out_ready = $urandom_range(0, 2) != 0;
            @(posedge clk); #1;
        end
        reset = 0; in_valid = 0; out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
